alu_frame_ctrl: RTL and testbench
=================================

Name: alu_frame_ctrl

Overview:
Parametrised successor to the single-byte UART ALU control FSM.
- Sits between uart_rx/uart_tx and a DATA_W-wide alu.
- Parses framed, checksummed, multi-byte commands and detects inter-byte timeouts.
- Returns a status byte plus the little-endian result, with explicit error reporting.

Parameters:
- DATA_W, 16: operand/result width; must be a multiple of 8 and ≥ 8; NB = DATA_W/8 bytes.
- OP_W, 3: ALU select width (≤ 7).
- SYNC_BYTE, 8'hA5: frame start marker.
- TIMEOUT_CYC, 100000: max clk cycles between bytes inside a frame; ≥ 2.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous active-high reset.
- rx_data  in  8  byte from uart_rx.
- rx_valid  in  1  one-cycle strobe; rx_data valid.
- tx_busy  in  1  uart_tx busy; rises the cycle after tx_start, low when idle.
- alu_result  in  DATA_W  combinational ALU output.
- alu_zero  in  1  ALU zero flag.
- tx_data  out  8  byte to uart_tx; held stable until tx_busy falls.
- tx_start  out  1  one-cycle send strobe.
- alu_a  out  DATA_W  registered operand A.
- alu_b  out  DATA_W  registered operand B.
- alu_op  out  OP_W  registered operation select.
- busy  out  1  high from SYNC accepted until last response byte completes.
- frame_err  out  1  one-cycle pulse when an error status is queued.

Behaviour:
- Reset (async, any state): all outputs 0, state IDLE, byte counter 0, checksum 0, timer 0. Response in flight is abandoned; tx_start never pulses during rst.
- Frame: SYNC, OP, A[NB bytes, LSB first], B[NB bytes, LSB first], CHK.
  - CHK = XOR of OP, A, and B bytes.
  - OP bits [7:OP_W] must be 0; otherwise the op is bad.
- Response:
  - OK: status 8'h80 | alu_zero, then NB result bytes, LSB first.
  - Errors send the single byte:
    - E1: checksum mismatch.
    - E2: bad op (takes priority over E1).
    - E3: timeout.
- States:
  - IDLE: non-SYNC bytes are ignored. On SYNC: go to OP, clear checksum, busy=1.
  - OP: latch alu_op from rx_data[OP_W-1:0]; record bad-op flag; go to A.
  - A, B: shift each byte into the operand at position byte_cnt*8. Leave after NB bytes; byte_cnt resets to 0 on each entry.
  - CHK: compare the byte with the running XOR. Mismatch or bad-op: go to SEND with the error code. Otherwise go to EXEC.
  - EXEC: exactly 1 cycle; capture alu_result and alu_zero into result_q. Queue the status byte.
  - SEND: if !tx_busy, drive tx_data and pulse tx_start; go to WAIT_HI.
  - WAIT_HI: wait for tx_busy=1.
  - WAIT_LO: wait for tx_busy=0. If more bytes are queued, go to SEND; else go to IDLE with busy=0.
- alu_a, alu_b, alu_op update only in OP/A/B and are held otherwise.
- Latency: CHK rx_valid at cycle n gives EXEC at n+1 and the first tx_start at n+2, provided tx_busy=0.
- Timeout:
  - Timer runs in OP, A, B and CHK; it clears on every rx_valid.
  - Reaching TIMEOUT_CYC-1 forces SEND with E3.
  - If rx_valid arrives on the same cycle the timer expires, the byte wins and the timer clears.
- rx_valid bytes arriving during EXEC/SEND/WAIT_* are dropped, including SYNC. They do not affect the next frame.
- A SYNC value inside the payload is treated as data; there is no resynchronisation.
- frame_err pulses on the cycle an error code is queued.

Decomposition:
- Package alu_frame_pkg holds:
  - the state enum;
  - status constants ST_OK=8'h80, ST_CHK=8'hE1, ST_OP=8'hE2, ST_TMO=8'hE3;
  - the default SYNC_BYTE.
- One sub-module, byte_timeout_timer (params TIMEOUT_CYC).
  - Inputs: enable, clear.
  - Output: expired pulse.
  - Counter width is $clog2(TIMEOUT_CYC).

Test Plan:
The bench runs DATA_W=16 with a stub ALU (op0=A+B, op1=A-B) and a uart_tx model that has busy for 10 cycles.

1. Add: A5 00 34 12 01 00 27 → tx bytes 80 35 12; alu_a=1234, alu_b=0001; tx_start 2 cycles after CHK; busy falls after the last byte.
2. Bad checksum: A5 00 34 12 01 00 28 → single byte E1; frame_err pulse; alu_op=0; next good frame answers normally.
3. Bad op, bad checksum: A5 08 00 00 00 00 00 → single E2 (priority over E1).
4. Zero flag and garbage: 55 A5 01 05 00 05 00 01 → leading 55 ignored; response 81 00 00.
5. Timeout: A5 00 34 then idle for TIMEOUT_CYC cycles → single E3.
   - Repeat with a byte landing exactly on the expiry cycle → no E3; frame completes.
6. Reset mid-response: assert rst while WAIT_LO of the first result byte → outputs 0 immediately; after release, no further tx_start until a new frame; bytes sent during the response are confirmed dropped.

Source files
------------

// File: rtl/alu_frame_pkg.sv
// Shared types and constants for the framed UART ALU controller.
package alu_frame_pkg;

  typedef enum logic [3:0] {
    S_IDLE,
    S_OP,
    S_A,
    S_B,
    S_CHK,
    S_EXEC,
    S_SEND,
    S_WAIT_HI,
    S_WAIT_LO
  } state_t;

  localparam logic [7:0] ST_OK  = 8'h80;
  localparam logic [7:0] ST_CHK = 8'hE1;
  localparam logic [7:0] ST_OP  = 8'hE2;
  localparam logic [7:0] ST_TMO = 8'hE3;

  localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'hA5;

endpackage

// File: rtl/byte_timeout_timer.sv
// Inter-byte watchdog: counts enabled cycles since the last clear and flags expiry.
module byte_timeout_timer #(
  parameter int TIMEOUT_CYC = 100000
) (
  input  logic clk,
  input  logic rst,
  input  logic enable,
  input  logic clear,
  output logic expired
);

  localparam int            CW   = $clog2(TIMEOUT_CYC);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYC - 1);

  logic [CW-1:0] count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clear || !enable) begin
      count <= '0;
    end else if (count != LAST) begin
      count <= count + CW'(1);
    end
  end

  // A byte arriving on the expiry cycle wins, so clear masks the flag.
  assign expired = enable && !clear && (count == LAST);

endmodule

// File: rtl/alu_frame_ctrl.sv
// Framed, checksummed command parser between a UART pair and a DATA_W-wide ALU,
// returning a status byte plus the little-endian result or a single error byte.
module alu_frame_ctrl
  import alu_frame_pkg::*;
#(
  parameter int         DATA_W      = 16,
  parameter int         OP_W        = 3,
  parameter logic [7:0] SYNC_BYTE   = DEFAULT_SYNC_BYTE,
  parameter int         TIMEOUT_CYC = 100000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  input  logic              tx_busy,
  input  logic [DATA_W-1:0] alu_result,
  input  logic              alu_zero,
  output logic [7:0]        tx_data,
  output logic              tx_start,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [OP_W-1:0]   alu_op,
  output logic              busy,
  output logic              frame_err
);

  localparam int NB     = DATA_W / 8;
  localparam int CNT_W  = (NB > 1) ? $clog2(NB) : 1;
  localparam int LEFT_W = $clog2(NB + 2);

  localparam logic [CNT_W-1:0]  LAST_BYTE = CNT_W'(NB - 1);
  localparam logic [LEFT_W-1:0] OK_BYTES  = LEFT_W'(NB + 1);

  state_t              state;
  logic [CNT_W-1:0]    byte_cnt;
  logic [7:0]          chk;
  logic                bad_op;
  logic [DATA_W+7:0]   resp_q;
  logic [LEFT_W-1:0]   bytes_left;
  logic                tmo_expired;
  logic                timer_en;

  assign timer_en = (state == S_OP) || (state == S_A) ||
                    (state == S_B)  || (state == S_CHK);

  byte_timeout_timer #(
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_timer (
    .clk     (clk),
    .rst     (rst),
    .enable  (timer_en),
    .clear   (rx_valid),
    .expired (tmo_expired)
  );

  // NOTE: all state and registered outputs use non-blocking assignments so every
  // branch sees the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      byte_cnt   <= '0;
      chk        <= '0;
      bad_op     <= 1'b0;
      resp_q     <= '0;
      bytes_left <= '0;
      tx_data    <= '0;
      tx_start   <= 1'b0;
      alu_a      <= '0;
      alu_b      <= '0;
      alu_op     <= '0;
      busy       <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      tx_start  <= 1'b0;
      frame_err <= 1'b0;
      if (tmo_expired) begin
        resp_q     <= {{DATA_W{1'b0}}, ST_TMO};
        bytes_left <= LEFT_W'(1);
        frame_err  <= 1'b1;
        state      <= S_SEND;
      end else begin
        case (state)
          S_IDLE: begin
            if (rx_valid && rx_data == SYNC_BYTE) begin
              chk   <= '0;
              busy  <= 1'b1;
              state <= S_OP;
            end
          end
          S_OP: begin
            if (rx_valid) begin
              alu_op   <= rx_data[OP_W-1:0];
              bad_op   <= |rx_data[7:OP_W];
              chk      <= chk ^ rx_data;
              byte_cnt <= '0;
              state    <= S_A;
            end
          end
          S_A: begin
            if (rx_valid) begin
              alu_a[{byte_cnt, 3'b000} +: 8] <= rx_data;
              chk <= chk ^ rx_data;
              if (byte_cnt == LAST_BYTE) begin
                byte_cnt <= '0;
                state    <= S_B;
              end else begin
                byte_cnt <= byte_cnt + CNT_W'(1);
              end
            end
          end
          S_B: begin
            if (rx_valid) begin
              alu_b[{byte_cnt, 3'b000} +: 8] <= rx_data;
              chk <= chk ^ rx_data;
              if (byte_cnt == LAST_BYTE) begin
                byte_cnt <= '0;
                state    <= S_CHK;
              end else begin
                byte_cnt <= byte_cnt + CNT_W'(1);
              end
            end
          end
          S_CHK: begin
            if (rx_valid) begin
              if (bad_op || rx_data != chk) begin
                resp_q     <= {{DATA_W{1'b0}}, (bad_op ? ST_OP : ST_CHK)};
                bytes_left <= LEFT_W'(1);
                frame_err  <= 1'b1;
                state      <= S_SEND;
              end else begin
                state <= S_EXEC;
              end
            end
          end
          S_EXEC: begin
            resp_q     <= {alu_result, ST_OK | {7'b0, alu_zero}};
            bytes_left <= OK_BYTES;
            state      <= S_SEND;
          end
          S_SEND: begin
            if (!tx_busy) begin
              tx_data    <= resp_q[7:0];
              tx_start   <= 1'b1;
              resp_q     <= resp_q >> 8;
              bytes_left <= bytes_left - LEFT_W'(1);
              state      <= S_WAIT_HI;
            end
          end
          S_WAIT_HI: begin
            if (tx_busy) state <= S_WAIT_LO;
          end
          S_WAIT_LO: begin
            if (!tx_busy) begin
              if (bytes_left != '0) begin
                state <= S_SEND;
              end else begin
                busy  <= 1'b0;
                state <= S_IDLE;
              end
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_alu_frame_ctrl.sv
// Directed bench for alu_frame_ctrl with a stub ALU and a 10-cycle uart_tx model.
module tb_alu_frame_ctrl;

  localparam int DATA_W = 16;
  localparam int OP_W   = 3;
  localparam int TMO    = 20;

  logic              clk = 1'b0;
  logic              rst;
  logic [7:0]        rx_data;
  logic              rx_valid;
  logic              tx_busy = 1'b0;
  logic [DATA_W-1:0] alu_result;
  logic              alu_zero;
  logic [7:0]        tx_data;
  logic              tx_start;
  logic [DATA_W-1:0] alu_a;
  logic [DATA_W-1:0] alu_b;
  logic [OP_W-1:0]   alu_op;
  logic              busy;
  logic              frame_err;

  int         errors = 0;
  int         checks = 0;
  int         busy_cnt = 0;
  logic [7:0] tx_log[$];

  always #5 clk = ~clk;

  alu_frame_ctrl #(
    .DATA_W      (DATA_W),
    .OP_W        (OP_W),
    .SYNC_BYTE   (8'hA5),
    .TIMEOUT_CYC (TMO)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .tx_busy    (tx_busy),
    .alu_result (alu_result),
    .alu_zero   (alu_zero),
    .tx_data    (tx_data),
    .tx_start   (tx_start),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_op     (alu_op),
    .busy       (busy),
    .frame_err  (frame_err)
  );

  assign alu_result = (alu_op == 3'd0) ? alu_a + alu_b :
                      (alu_op == 3'd1) ? alu_a - alu_b : '0;
  assign alu_zero   = (alu_result == '0);

  always @(posedge clk) begin
    if (tx_start) begin
      tx_busy  <= 1'b1;
      busy_cnt <= 10;
      tx_log.push_back(tx_data);
    end else if (busy_cnt > 1) begin
      busy_cnt <= busy_cnt - 1;
    end else begin
      busy_cnt <= 0;
      tx_busy  <= 1'b0;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; returns two negedges later with rx_valid low.
  task automatic send_byte(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
    @(negedge clk);
  endtask

  // Returns at the negedge right after the byte is sampled.
  task automatic send_last(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (busy !== 1'b0 && n < 400) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_busy_fell"}, busy, 0);
  endtask

  task automatic wait_log(input string tag, input int want);
    int n = 0;
    while (tx_log.size() < want && n < 400) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_log_reached"}, tx_log.size() >= want, 1);
  endtask

  task automatic check_resp(input string tag, input int n,
                            input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
    logic [7:0] exp[3];
    exp = '{b0, b1, b2};
    check({tag, "_count"}, tx_log.size(), n);
    for (int i = 0; i < n && i < tx_log.size(); i++)
      check($sformatf("%s_byte%0d", tag, i), tx_log[i], exp[i]);
  endtask

  initial begin
    int held;
    rst      = 1'b1;
    rx_data  = 8'h00;
    rx_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_tx_start", tx_start, 0);
    check("rst_busy", busy, 0);
    check("rst_alu_a", alu_a, 0);
    check("rst_tx_data", tx_data, 0);
    rst = 1'b0;
    @(negedge clk);

    // 1. add with latency
    tx_log.delete();
    send_byte(8'hA5); send_byte(8'h00); send_byte(8'h34); send_byte(8'h12);
    send_byte(8'h01); send_byte(8'h00);
    check("add_busy", busy, 1);
    send_last(8'h27);
    check("add_no_err", frame_err, 0);
    @(posedge clk); #1;
    check("add_lat_n1", tx_start, 0);
    @(posedge clk); #1;
    check("add_lat_n2", tx_start, 1);
    check("add_alu_a", alu_a, 16'h1234);
    check("add_alu_b", alu_b, 16'h0001);
    check("add_alu_op", alu_op, 0);
    @(negedge clk);
    wait_idle("add");
    check("add_txbusy_low", tx_busy, 0);
    check_resp("add", 3, 8'h80, 8'h35, 8'h12);

    // 2. bad checksum, then a good subtract frame
    tx_log.delete();
    send_byte(8'hA5); send_byte(8'h00); send_byte(8'h34); send_byte(8'h12);
    send_byte(8'h01); send_byte(8'h00);
    send_last(8'h28);
    check("chk_err_pulse", frame_err, 1);
    @(negedge clk);
    check("chk_err_end", frame_err, 0);
    check("chk_alu_op", alu_op, 0);
    wait_idle("chk");
    check_resp("chk", 1, 8'hE1, 8'h00, 8'h00);
    tx_log.delete();
    send_byte(8'hA5); send_byte(8'h01); send_byte(8'h10); send_byte(8'h00);
    send_byte(8'h03); send_byte(8'h00); send_byte(8'h12);
    wait_idle("sub");
    check("sub_alu_op", alu_op, 1);
    check_resp("sub", 3, 8'h80, 8'h0D, 8'h00);

    // 3. bad op has priority over bad checksum
    tx_log.delete();
    send_byte(8'hA5); send_byte(8'h08); send_byte(8'h00); send_byte(8'h00);
    send_byte(8'h00); send_byte(8'h00);
    send_last(8'h00);
    check("op_err_pulse", frame_err, 1);
    @(negedge clk);
    wait_idle("op");
    check_resp("op", 1, 8'hE2, 8'h00, 8'h00);

    // 4. leading garbage, zero flag, bytes during the response are dropped
    tx_log.delete();
    send_byte(8'h55);
    check("garbage_ignored", busy, 0);
    send_byte(8'hA5); send_byte(8'h01); send_byte(8'h05); send_byte(8'h00);
    send_byte(8'h05); send_byte(8'h00); send_byte(8'h01);
    wait_log("zero", 1);
    send_byte(8'hA5); send_byte(8'h00);
    wait_idle("zero");
    check_resp("zero", 3, 8'h81, 8'h00, 8'h00);

    // 5a. timeout after the first A byte
    tx_log.delete();
    send_byte(8'hA5); send_byte(8'h00); send_byte(8'h34);
    repeat (TMO - 2) @(negedge clk);
    check("tmo_not_yet", frame_err, 0);
    @(negedge clk);
    check("tmo_err_pulse", frame_err, 1);
    wait_idle("tmo");
    check_resp("tmo", 1, 8'hE3, 8'h00, 8'h00);

    // 5b. byte lands exactly on the expiry cycle and wins
    tx_log.delete();
    send_byte(8'hA5); send_byte(8'h00); send_byte(8'h34);
    repeat (TMO - 2) @(negedge clk);
    send_last(8'h12);
    check("edge_no_err", frame_err, 0);
    @(negedge clk);
    send_byte(8'h01); send_byte(8'h00); send_byte(8'h27);
    wait_idle("edge");
    check_resp("edge", 3, 8'h80, 8'h35, 8'h12);

    // 6. reset while waiting on the first result byte
    tx_log.delete();
    send_byte(8'hA5); send_byte(8'h00); send_byte(8'h34); send_byte(8'h12);
    send_byte(8'h01); send_byte(8'h00); send_byte(8'h27);
    wait_log("rstmid_first", 1);
    send_byte(8'hA5); send_byte(8'h01);
    wait_log("rstmid_second", 2);
    repeat (4) @(negedge clk);
    check("rstmid_busy_before", busy, 1);
    rst = 1'b1;
    #1;
    check("rstmid_busy", busy, 0);
    check("rstmid_tx_data", tx_data, 0);
    check("rstmid_alu_a", alu_a, 0);
    check("rstmid_alu_b", alu_b, 0);
    check("rstmid_alu_op", alu_op, 0);
    check("rstmid_tx_start", tx_start, 0);
    @(negedge clk);
    rst = 1'b0;
    held = tx_log.size();
    repeat (40) @(negedge clk);
    check("rstmid_quiet", tx_log.size(), held);
    check("rstmid_idle", busy, 0);
    tx_log.delete();
    send_byte(8'hA5); send_byte(8'h00); send_byte(8'h34); send_byte(8'h12);
    send_byte(8'h01); send_byte(8'h00); send_byte(8'h27);
    wait_idle("after_rst");
    check_resp("after_rst", 3, 8'h80, 8'h35, 8'h12);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
